rom_fetch_sched: RTL

//  Sequences the single asynchronous program-ROM read port (11-bit addr, 29-bit word).

---
 rtl/rom_fetch_sched_pkg.sv | 14 +
 rtl/rom_fetch_sched_fetch_queue.sv | 83 ++++++++
 rtl/rom_fetch_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rom_fetch_sched_pkg.sv
// Shared constants and grant-state encoding for the program-ROM fetch scheduler.
package rom_fetch_sched_pkg;

  // Default program-ROM geometry
  localparam int ROM_ADDR_W = 11;
  localparam int ROM_DATA_W = 29;

  // Owner of the single ROM read port in the current cycle
  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DBG   = 1'b1
  } grant_state_e;

endpackage : rom_fetch_sched_pkg

// File: rtl/rom_fetch_sched_fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} pairs in front of the decoder.
// A flush empties it in one cycle and wins over a same-cycle push or pop.
module fetch_queue
  import rom_fetch_sched_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = QDEPTH[PTR_W:0];

  logic [ADDR_W-1:0] pc_mem   [QDEPTH];
  logic [DATA_W-1:0] data_mem [QDEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign valid_o     = (count_q != '0);
  assign full_o      = (count_q == DEPTH_C);
  assign head_pc_o   = valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign head_data_o = valid_o ? data_mem[rd_ptr_q] : '0;

  // Next-state for pointers and occupancy; a push into a full queue only lands alongside a pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i && valid_o && !flush_i;
    push_ok  = push_i && !flush_i && (!full_o || pop_ok);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; empty entries are masked at the output so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]   <= push_pc_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : fetch_queue

// File: rtl/rom_fetch_sched.sv
// Program-ROM port scheduler: arbitrates the single asynchronous ROM read port
// between instruction prefetch and a debug/loader read, with bounded debug starvation.
module rom_fetch_sched
  import rom_fetch_sched_pkg::*;
#(
  parameter int                 ADDR_W     = ROM_ADDR_W,
  parameter int                 DATA_W     = ROM_DATA_W,
  parameter int                 QDEPTH     = 2,
  parameter int                 STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  grant_state_e        state_q,    state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [STARVE_W-1:0] starve_q,   starve_d;
  logic                dbg_ack_q,  dbg_ack_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;

  logic q_push;
  logic q_pop;
  logic q_full;
  logic dbg_pend;
  logic full_no_pop;

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redir_valid),
    .push_i      (q_push),
    .push_pc_i   (fetch_pc_q),
    .push_data_i (rom_data),
    .pop_i       (q_pop),
    .valid_o     (instr_valid),
    .full_o      (q_full),
    .head_pc_o   (instr_pc),
    .head_data_o (instr_data)
  );

  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;

  // Grant FSM: picks the ROM address, decides push/PC advance, and tracks debug starvation
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    starve_d    = starve_q;
    dbg_ack_d   = 1'b0;
    dbg_data_d  = dbg_data_q;
    rom_addr    = fetch_pc_q;
    q_push      = 1'b0;
    // A redirect discards the head, so the CPU's ready is not a pop that cycle
    q_pop       = instr_valid && instr_ready && !redir_valid;
    // The cycle dbg_ack is visible the requester is still dropping its request
    dbg_pend    = dbg_req && !dbg_ack_q;
    full_no_pop = q_full && !q_pop && !redir_valid;
    case (state_q)
      S_FETCH: begin
        rom_addr = fetch_pc_q;
        if (redir_valid) begin
          fetch_pc_d = redir_pc;
        end else if (!q_full || q_pop) begin
          q_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + 1'b1;
        end
        if (dbg_pend && (full_no_pop || starve_q == STARVE_LIM)) begin
          state_d  = S_DBG;
          starve_d = '0;
        end else if (dbg_pend) begin
          starve_d = starve_q + 1'b1;
        end
      end
      S_DBG: begin
        rom_addr   = dbg_addr;
        dbg_data_d = rom_data;
        dbg_ack_d  = 1'b1;
        starve_d   = '0;
        state_d    = S_FETCH;
        if (redir_valid) fetch_pc_d = redir_pc;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, PC, starvation counter and registered debug read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      starve_q   <= '0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      starve_q   <= starve_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end

endmodule : rom_fetch_sched
